// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
// Definitions shared by the core pipeline stages.
//   fetch_state_t    : instruction-fetch FSM state encoding
//   NOP_INSTR        : canonical NOP (addi x0, x0, 0), presented for faulted fetches
//   RESET_PC_DEFAULT : default address of the first fetch after reset
// -----------------------------------------------------------------------------
package core_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,   // one settling cycle after reset release
      REQ  = 3'd1,   // request presented to instruction memory
      WAIT = 3'd2,   // request accepted, waiting for the response
      DROP = 3'd3,   // request accepted but squashed; swallow its response
      FULL = 3'd4    // instruction held for decode
   } fetch_state_t;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage
// Instruction-fetch stage. Holds the program counter, issues one instruction
// memory request at a time and hands the fetched instruction to decode.
//
// Parameters
//   RESET_PC        : address of the first fetch after reset
// Ports
//   clk, rst_n      : clock (rising edge), asynchronous active-low reset
//   next_pc         : next PC chosen by the external PC mux
//   redirect        : taken branch / jump (PC mux select); highest priority
//   pc_plus4        : pc_q + 4, sequential input of the PC mux
//   imem_req_*      : request handshake; imem_req_addr is always pc_q
//   imem_rsp_*      : single-cycle response, no backpressure
//   id_valid/ready  : handshake to decode
//   id_instr, id_pc : fetched instruction and its address
//   fetch_fault     : misaligned fetch flag, meaningful only with id_valid
//
// Build option
//   IF_MISALIGN_CHK_EN : when defined, a fetch from a PC with pc_q[1:0] != 0
//   issues no request; a NOP with fetch_fault=1 is presented instead and held
//   until a redirect. When undefined, fetch_fault is tied to 0.
// -----------------------------------------------------------------------------
module if_stage
   import core_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] next_pc,
   input  logic        redirect,
   output logic [31:0] pc_plus4,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc,
   output logic        fetch_fault
);

   fetch_state_t state_q, state_next;
   logic [31:0]  pc_q, pc_next;
   logic [31:0]  id_instr_q, id_instr_next;
   logic [31:0]  id_pc_q;
   logic         load_id;
   logic         misaligned;
   logic         fault_hold;

`ifdef IF_MISALIGN_CHK_EN
   logic fault_q, fault_next;
   assign misaligned  = (pc_q[1:0] != 2'b00);
   // A faulted fetch parks in FULL; only a redirect moves it on.
   assign fault_hold  = fault_q;
   assign fetch_fault = fault_q;
`else
   assign misaligned  = 1'b0;
   assign fault_hold  = 1'b0;
   assign fetch_fault = 1'b0;
`endif

   assign pc_plus4       = pc_q + 32'd4;
   assign imem_req_addr  = pc_q;
   assign imem_req_valid = (state_q == REQ) && !misaligned;
   // A redirect in the same cycle squashes the held instruction.
   assign id_valid       = (state_q == FULL) && !redirect;
   assign id_instr       = id_instr_q;
   assign id_pc          = id_pc_q;

   always_comb begin
      state_next    = state_q;
      pc_next       = pc_q;
      load_id       = 1'b0;
      id_instr_next = imem_rsp_data;
`ifdef IF_MISALIGN_CHK_EN
      fault_next    = 1'b0;
`endif
      // Redirect always retargets the PC, whatever the state.
      if (redirect) begin
         pc_next = next_pc;
      end

      case (state_q)
         IDLE: begin
            state_next = REQ;
         end
         REQ: begin
            if (redirect) begin
               // An accepted request is still in flight and must be drained.
               state_next = (imem_req_valid && imem_req_ready) ? DROP : REQ;
            end
`ifdef IF_MISALIGN_CHK_EN
            else if (misaligned) begin
               load_id       = 1'b1;
               id_instr_next = NOP_INSTR;
               fault_next    = 1'b1;
               state_next    = FULL;
            end
`endif
            else if (imem_req_ready) begin
               state_next = WAIT;
            end
         end
         WAIT: begin
            if (redirect) begin
               // A response in the same cycle belongs to the squashed fetch.
               state_next = imem_rsp_valid ? REQ : DROP;
            end else if (imem_rsp_valid) begin
               load_id    = 1'b1;
               pc_next    = next_pc;
               state_next = FULL;
            end
         end
         DROP: begin
            if (imem_rsp_valid) begin
               state_next = REQ;
            end
         end
         FULL: begin
            if (redirect) begin
               state_next = REQ;
            end else if (id_ready && !fault_hold) begin
               state_next = REQ;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         pc_q       <= RESET_PC;
         id_instr_q <= 32'h0000_0000;
         id_pc_q    <= 32'h0000_0000;
`ifdef IF_MISALIGN_CHK_EN
         fault_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_next;
         pc_q    <= pc_next;
         if (load_id) begin
            id_instr_q <= id_instr_next;
            id_pc_q    <= pc_q;
`ifdef IF_MISALIGN_CHK_EN
            fault_q    <= fault_next;
`endif
         end
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// -----------------------------------------------------------------------------
// tb_if_stage
// Directed, table-driven bench for if_stage. Each table row is one clock
// cycle: inputs driven after the falling edge, outputs compared 1 ns later.
// Reset behaviour is exercised by a short hand-written sequence.
// Honours IF_MISALIGN_CHK_EN so the same bench covers both builds.
// -----------------------------------------------------------------------------
module tb_if_stage;

   logic        clk;
   logic        rst_n;
   logic [31:0] next_pc;
   logic        redirect;
   logic [31:0] pc_plus4;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
   logic        fetch_fault;

   int n_cmp  = 0;
   int n_fail = 0;

   if_stage #(.RESET_PC(32'h0000_0000)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .next_pc        (next_pc),
      .redirect       (redirect),
      .pc_plus4       (pc_plus4),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .id_valid       (id_valid),
      .id_ready       (id_ready),
      .id_instr       (id_instr),
      .id_pc          (id_pc),
      .fetch_fault    (fetch_fault)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic        rd;
      logic [31:0] npc;
      logic        rdy;
      logic        rv;
      logic [31:0] rdata;
      logic        idr;
      logic        e_rv;
      logic [31:0] e_addr;
      logic        e_idv;
      logic [31:0] e_instr;
      logic [31:0] e_idpc;
      logic        e_fault;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic rd, logic [31:0] npc, logic rdy, logic rv,
                               logic [31:0] rdata, logic idr, logic e_rv,
                               logic [31:0] e_addr, logic e_idv,
                               logic [31:0] e_instr, logic [31:0] e_idpc,
                               logic e_fault);
      vec_t v;
      v.rd = rd; v.npc = npc; v.rdy = rdy; v.rv = rv; v.rdata = rdata; v.idr = idr;
      v.e_rv = e_rv; v.e_addr = e_addr; v.e_idv = e_idv;
      v.e_instr = e_instr; v.e_idpc = e_idpc; v.e_fault = e_fault;
      return v;
   endfunction

   task automatic chk(input string nm, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s vec %0d: got %h, expected %h", nm, idx, act, exp);
      end
   endtask

   task automatic run_vec(input int idx);
      vec_t        v;
      logic [31:0] exp_p4;
      v = vecs[idx];
      @(negedge clk);
      redirect       = v.rd;
      next_pc        = v.npc;
      imem_req_ready = v.rdy;
      imem_rsp_valid = v.rv;
      imem_rsp_data  = v.rdata;
      id_ready       = v.idr;
      #1;
      exp_p4 = v.e_addr + 32'd4;
      chk("imem_req_valid", idx, {31'b0, imem_req_valid}, {31'b0, v.e_rv});
      chk("imem_req_addr",  idx, imem_req_addr, v.e_addr);
      chk("pc_plus4",       idx, pc_plus4, exp_p4);
      chk("id_valid",       idx, {31'b0, id_valid}, {31'b0, v.e_idv});
      chk("id_instr",       idx, id_instr, v.e_instr);
      chk("id_pc",          idx, id_pc, v.e_idpc);
      chk("fetch_fault",    idx, {31'b0, fetch_fault}, {31'b0, v.e_fault});
      $display("vec %0d: redirect=%0b req_valid=%0b addr=%h id_valid=%0b instr=%h id_pc=%h fault=%0b",
               idx, v.rd, imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc, fetch_fault);
   endtask

`ifdef IF_MISALIGN_CHK_EN
   localparam logic [31:0] LAST_INSTR = 32'h0000_0013;
   localparam logic [31:0] LAST_IDPC  = 32'h0000_0102;
   localparam logic        LAST_FAULT = 1'b1;
`else
   localparam logic [31:0] LAST_INSTR = 32'hA700_0000;
   localparam logic [31:0] LAST_IDPC  = 32'h0000_0000;
   localparam logic        LAST_FAULT = 1'b0;
`endif

   int n_main;

   initial begin
      // ---------------- table: rd npc rdy rv rdata idr | rv addr idv instr idpc fault
      // Straight-line fetch 0,4,8,C: one id_valid every 3 cycles.
      vecs.push_back(mk(0, 32'h4,  1, 0, 0,            1, 1, 32'h0, 0, 0,            0,     0));
      vecs.push_back(mk(0, 32'h4,  0, 1, 32'hA000_0000, 1, 0, 32'h0, 0, 0,            0,     0));
      vecs.push_back(mk(0, 32'h8,  0, 0, 0,            1, 0, 32'h4, 1, 32'hA000_0000, 32'h0, 0));
      vecs.push_back(mk(0, 32'h8,  1, 0, 0,            1, 1, 32'h4, 0, 32'hA000_0000, 32'h0, 0));
      vecs.push_back(mk(0, 32'h8,  0, 1, 32'hA100_0000, 1, 0, 32'h4, 0, 32'hA000_0000, 32'h0, 0));
      vecs.push_back(mk(0, 32'hC,  0, 0, 0,            1, 0, 32'h8, 1, 32'hA100_0000, 32'h4, 0));
      vecs.push_back(mk(0, 32'hC,  1, 0, 0,            1, 1, 32'h8, 0, 32'hA100_0000, 32'h4, 0));
      vecs.push_back(mk(0, 32'hC,  0, 1, 32'hA200_0000, 1, 0, 32'h8, 0, 32'hA100_0000, 32'h4, 0));
      vecs.push_back(mk(0, 32'h10, 0, 0, 0,            1, 0, 32'hC, 1, 32'hA200_0000, 32'h8, 0));
      vecs.push_back(mk(0, 32'h10, 1, 0, 0,            1, 1, 32'hC, 0, 32'hA200_0000, 32'h8, 0));
      vecs.push_back(mk(0, 32'h10, 0, 1, 32'hA300_0000, 1, 0, 32'hC, 0, 32'hA200_0000, 32'h8, 0));
      // Decode stalls for 5 cycles: outputs held, no request.
      for (int i = 0; i < 5; i++)
         vecs.push_back(mk(0, 32'h14, 1, 0, 0,         0, 0, 32'h10, 1, 32'hA300_0000, 32'hC, 0));
      vecs.push_back(mk(0, 32'h14, 0, 0, 0,            1, 0, 32'h10, 1, 32'hA300_0000, 32'hC, 0));
      // Redirect to 0x100 in WAIT; stale response two cycles later is dropped.
      vecs.push_back(mk(0, 32'h14, 1, 0, 0,            1, 1, 32'h10,  0, 32'hA300_0000, 32'hC, 0));
      vecs.push_back(mk(1, 32'h100,0, 0, 0,            1, 0, 32'h10,  0, 32'hA300_0000, 32'hC, 0));
      vecs.push_back(mk(0, 32'h104,0, 0, 0,            1, 0, 32'h100, 0, 32'hA300_0000, 32'hC, 0));
      vecs.push_back(mk(0, 32'h104,0, 1, 32'hDEAD_BEEF, 1, 0, 32'h100, 0, 32'hA300_0000, 32'hC, 0));
      vecs.push_back(mk(0, 32'h104,1, 0, 0,            1, 1, 32'h100, 0, 32'hA300_0000, 32'hC, 0));
      vecs.push_back(mk(0, 32'h104,0, 1, 32'hA400_0000, 1, 0, 32'h100, 0, 32'hA300_0000, 32'hC, 0));
      // Redirect in FULL together with id_ready: instruction squashed.
      vecs.push_back(mk(1, 32'h200,0, 0, 0,            1, 0, 32'h104, 0, 32'hA400_0000, 32'h100, 0));
      // Redirect in REQ without acceptance: stays in REQ at new address.
      vecs.push_back(mk(1, 32'h300,0, 0, 0,            1, 1, 32'h200, 0, 32'hA400_0000, 32'h100, 0));
      // Redirect in REQ with acceptance: response must be drained.
      vecs.push_back(mk(1, 32'h400,1, 0, 0,            1, 1, 32'h300, 0, 32'hA400_0000, 32'h100, 0));
      vecs.push_back(mk(0, 32'h404,0, 1, 32'hBAD1_0000, 1, 0, 32'h400, 0, 32'hA400_0000, 32'h100, 0));
      vecs.push_back(mk(0, 32'h404,1, 0, 0,            1, 1, 32'h400, 0, 32'hA400_0000, 32'h100, 0));
      // Redirect in WAIT with a same-cycle response: response discarded.
      vecs.push_back(mk(1, 32'h500,0, 1, 32'hBAD2_0000, 1, 0, 32'h400, 0, 32'hA400_0000, 32'h100, 0));
      vecs.push_back(mk(0, 32'h504,0, 0, 0,            1, 1, 32'h500, 0, 32'hA400_0000, 32'h100, 0));
      vecs.push_back(mk(0, 32'h504,1, 0, 0,            1, 1, 32'h500, 0, 32'hA400_0000, 32'h100, 0));
      vecs.push_back(mk(0, 32'h504,0, 1, 32'hA500_0000, 1, 0, 32'h500, 0, 32'hA400_0000, 32'h100, 0));
      vecs.push_back(mk(0, 32'h508,0, 0, 0,            1, 0, 32'h504, 1, 32'hA500_0000, 32'h500, 0));
      // PC wrap: 0xFFFF_FFFC + 4 = 0.
      vecs.push_back(mk(1, 32'hFFFF_FFFC, 0, 0, 0,     1, 1, 32'h504, 0, 32'hA500_0000, 32'h500, 0));
      vecs.push_back(mk(0, 32'h0,  1, 0, 0,            1, 1, 32'hFFFF_FFFC, 0, 32'hA500_0000, 32'h500, 0));
      vecs.push_back(mk(0, 32'h0,  0, 1, 32'hA600_0000, 1, 0, 32'hFFFF_FFFC, 0, 32'hA500_0000, 32'h500, 0));
      vecs.push_back(mk(0, 32'h4,  0, 0, 0,            1, 0, 32'h0, 1, 32'hA600_0000, 32'hFFFF_FFFC, 0));
      // Stale response while in REQ is ignored.
      vecs.push_back(mk(0, 32'h4,  0, 1, 32'hBAD3_0000, 1, 1, 32'h0, 0, 32'hA600_0000, 32'hFFFF_FFFC, 0));
      vecs.push_back(mk(0, 32'h4,  1, 0, 0,            1, 1, 32'h0, 0, 32'hA600_0000, 32'hFFFF_FFFC, 0));
      vecs.push_back(mk(0, 32'h4,  0, 1, 32'hA700_0000, 1, 0, 32'h0, 0, 32'hA600_0000, 32'hFFFF_FFFC, 0));
      vecs.push_back(mk(0, 32'h8,  0, 0, 0,            0, 0, 32'h4, 1, 32'hA700_0000, 32'h0, 0));
      // Redirect to misaligned 0x102.
      vecs.push_back(mk(1, 32'h102,0, 0, 0,            1, 0, 32'h4, 0, 32'hA700_0000, 32'h0, 0));
`ifdef IF_MISALIGN_CHK_EN
      vecs.push_back(mk(0, 32'h106,1, 0, 0,            1, 0, 32'h102, 0, 32'hA700_0000, 32'h0, 0));
      vecs.push_back(mk(0, 32'h106,0, 0, 0,            1, 0, 32'h102, 1, 32'h0000_0013, 32'h102, 1));
      vecs.push_back(mk(0, 32'h106,1, 1, 32'hBAD6_0000, 1, 0, 32'h102, 1, 32'h0000_0013, 32'h102, 1));
      vecs.push_back(mk(1, 32'h40, 0, 0, 0,            1, 0, 32'h102, 0, 32'h0000_0013, 32'h102, 1));
`else
      vecs.push_back(mk(1, 32'h40, 0, 0, 0,            1, 1, 32'h102, 0, 32'hA700_0000, 32'h0, 0));
`endif
      // Request at 0x40 accepted; reset will strike in WAIT.
      vecs.push_back(mk(0, 32'h44, 1, 0, 0,            1, 1, 32'h40, 0, LAST_INSTR, LAST_IDPC, LAST_FAULT));
      n_main = vecs.size();
      // After reset: late/stale responses ignored, next fetch from RESET_PC.
      vecs.push_back(mk(0, 32'h4,  0, 1, 32'hBAD5_0000, 1, 1, 32'h0, 0, 32'h0, 32'h0, 0));
      vecs.push_back(mk(0, 32'h4,  1, 0, 0,            1, 1, 32'h0, 0, 32'h0, 32'h0, 0));
      vecs.push_back(mk(0, 32'h4,  0, 1, 32'hC0DE_0000, 1, 0, 32'h0, 0, 32'h0, 32'h0, 0));
      vecs.push_back(mk(0, 32'h8,  0, 0, 0,            1, 0, 32'h4, 1, 32'hC0DE_0000, 32'h0, 0));

      // ---------------- reset state
      redirect = 1'b0; next_pc = 32'h0; imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0; id_ready = 1'b0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      chk("rst imem_req_valid", -1, {31'b0, imem_req_valid}, 32'h0);
      chk("rst imem_req_addr",  -1, imem_req_addr, 32'h0);
      chk("rst id_valid",       -1, {31'b0, id_valid}, 32'h0);
      chk("rst id_instr",       -1, id_instr, 32'h0);
      chk("rst id_pc",          -1, id_pc, 32'h0);
      chk("rst fetch_fault",    -1, {31'b0, fetch_fault}, 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      // IDLE cycle directly after release.
      chk("idle imem_req_valid", -1, {31'b0, imem_req_valid}, 32'h0);
      chk("idle id_valid",       -1, {31'b0, id_valid}, 32'h0);
      $display("reset released: req_valid=%0b id_valid=%0b", imem_req_valid, id_valid);

      for (int i = 0; i < n_main; i++) run_vec(i);

      // ---------------- asynchronous reset during WAIT (pc_q = 0x40)
      @(negedge clk);
      redirect = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; id_ready = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("arst imem_req_valid", -2, {31'b0, imem_req_valid}, 32'h0);
      chk("arst imem_req_addr",  -2, imem_req_addr, 32'h0);
      chk("arst pc_plus4",       -2, pc_plus4, 32'h4);
      chk("arst id_valid",       -2, {31'b0, id_valid}, 32'h0);
      chk("arst id_instr",       -2, id_instr, 32'h0);
      chk("arst id_pc",          -2, id_pc, 32'h0);
      chk("arst fetch_fault",    -2, {31'b0, fetch_fault}, 32'h0);
      $display("async reset in WAIT: addr=%h id_instr=%h", imem_req_addr, id_instr);
      @(negedge clk);
      // Late response lands in the IDLE cycle after release.
      rst_n = 1'b1; imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBAD4_0000; imem_req_ready = 1'b1;
      #1;
      chk("arst idle imem_req_valid", -2, {31'b0, imem_req_valid}, 32'h0);
      chk("arst idle id_valid",       -2, {31'b0, id_valid}, 32'h0);
      $display("reset released with late response: req_valid=%0b id_valid=%0b", imem_req_valid, id_valid);

      for (int i = n_main; i < vecs.size(); i++) run_vec(i);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   // Hard stop so a broken build can never hang the run.
   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete, expected finish before 100000 ns");
      $fatal(1, "timeout");
   end

endmodule
